// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter: miss handler between the I-cache/D-cache and main memory.
// Arbitrates the two miss requests (D-cache first), fetches the whole block for
// the winner and streams its words into that cache, then writes the tag.
// After reset it idles for MEM_LATENCY cycles so that stale memory returns are
// swallowed before any new fill can start.
module cache_fill_arbiter #(
    parameter int MEM_LATENCY = 4,
    parameter int WORDS       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_miss,
    input  logic [15:0]              i_miss_addr,
    input  logic                     d_miss,
    input  logic [15:0]              d_miss_addr,
    input  logic [15:0]              mem_data_in,
    input  logic                     mem_data_valid,
    output logic                     mem_en,
    output logic [15:0]              mem_addr,
    output logic                     fill_busy,
    output logic                     fill_owner,
    output logic                     fill_we,
    output logic [$clog2(WORDS)-1:0] fill_word,
    output logic [15:0]              fill_data,
    output logic                     fill_tag_we,
    output logic                     fill_done,
    output logic                     i_stall,
    output logic                     d_stall
);

    localparam int CNT_W  = $clog2(WORDS);
    localparam int WAIT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    // Clears the byte offset inside a block of 2*WORDS bytes.
    localparam logic [15:0] BLK_MASK  = ~16'(2 * WORDS - 1);
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WORDS - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MEM_LATENCY - 1);

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t             state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]   issue_cnt;
    logic [CNT_W-1:0]   rcv_cnt;
    logic [15:0]        base;
    logic               owner;

    logic               rcv_active;
    logic               rcv_take;
    logic               rcv_last;
    logic               issue_last;
    logic [15:0]        issue_offset;

    // Decode helpers shared by the state machine and the output logic.
    always_comb begin
        rcv_active   = (state == ST_ISSUE) || (state == ST_DRAIN);
        rcv_take     = rcv_active && mem_data_valid;
        rcv_last     = (rcv_cnt == LAST_WORD);
        issue_last   = (issue_cnt == LAST_WORD);
        issue_offset = {{(15 - CNT_W){1'b0}}, issue_cnt, 1'b0};
    end

    // Fill sequencer: post-reset wait, arbitration, issuing reads and counting returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_WAIT;
            wait_cnt  <= '0;
            issue_cnt <= '0;
            rcv_cnt   <= '0;
            base      <= '0;
            owner     <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wait_cnt == LAST_WAIT) begin
                        state <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (d_miss) begin
                        base      <= d_miss_addr & BLK_MASK;
                        owner     <= 1'b1;
                        issue_cnt <= '0;
                        rcv_cnt   <= '0;
                        state     <= ST_ISSUE;
                    end else if (i_miss) begin
                        base      <= i_miss_addr & BLK_MASK;
                        owner     <= 1'b0;
                        issue_cnt <= '0;
                        rcv_cnt   <= '0;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    issue_cnt <= issue_cnt + 1'b1;
                    if (issue_last) begin
                        state <= ST_DRAIN;
                    end
                    // A completed block overrides the issue progression.
                    if (rcv_take) begin
                        rcv_cnt <= rcv_cnt + 1'b1;
                        if (rcv_last) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (rcv_take) begin
                        rcv_cnt <= rcv_cnt + 1'b1;
                        if (rcv_last) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_WAIT;
                end
            endcase
        end
    end

    // Outputs decoded from the registered state; the write path follows the
    // memory valid directly so each word lands in the cycle it arrives.
    always_comb begin
        mem_en      = (state == ST_ISSUE);
        mem_addr    = mem_en ? (base + issue_offset) : 16'h0000;
        fill_busy   = (state == ST_ISSUE) || (state == ST_DRAIN) || (state == ST_DONE);
        fill_owner  = fill_busy & owner;
        fill_we     = rcv_take;
        fill_word   = rcv_take ? rcv_cnt : '0;
        fill_data   = rcv_take ? mem_data_in : 16'h0000;
        fill_tag_we = rcv_take & rcv_last;
        fill_done   = (state == ST_DONE);
        i_stall     = i_miss & ~(fill_done & ~owner);
        d_stall     = d_miss & ~(fill_done & owner);
    end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Testbench for cache_fill_arbiter: a latency-accurate memory model, a
// transaction-level reference of the fill rules, and a per-cycle monitor.
module tb_cache_fill_arbiter;

    localparam int LAT   = 4;
    localparam int WORDS = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_miss = 1'b0;
    logic [15:0] i_miss_addr = 16'h0000;
    logic        d_miss = 1'b0;
    logic [15:0] d_miss_addr = 16'h0000;
    logic [15:0] mem_data_in = 16'h0000;
    logic        mem_data_valid = 1'b0;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic        fill_busy;
    logic        fill_owner;
    logic        fill_we;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        fill_tag_we;
    logic        fill_done;
    logic        i_stall;
    logic        d_stall;

    cache_fill_arbiter #(.MEM_LATENCY(LAT), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid),
        .mem_en(mem_en), .mem_addr(mem_addr),
        .fill_busy(fill_busy), .fill_owner(fill_owner),
        .fill_we(fill_we), .fill_word(fill_word), .fill_data(fill_data),
        .fill_tag_we(fill_tag_we), .fill_done(fill_done),
        .i_stall(i_stall), .d_stall(d_stall)
    );

    always #5 clk = ~clk;

    // Cycle number: cycle c is the interval following the c-th rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } resp_t;

    resp_t       respQ[$];
    bit          gapMode = 1'b0;
    bit          strayEn = 1'b0;
    logic [15:0] salt = 16'h0000;

    bit          mdlActive = 1'b0;
    bit          mdlOwner = 1'b0;
    logic [15:0] mdlBase = 16'h0000;
    int          mdlStart = 0;
    int          mdlWritten = 0;
    int          mdlTag = -1;
    int          availIdle = 0;

    function automatic logic [15:0] memWord(logic [15:0] a);
        return {a[7:0], a[15:8]} ^ salt ^ 16'h3C5A;
    endfunction

    task automatic checkOutput(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Memory request capture: every read issued returns LAT cycles later.
    always @(negedge clk) begin
        if (mem_en === 1'b1) respQ.push_back('{addr: mem_addr, due: cyc + LAT});
    end

    // Memory return driver, optionally gappy, plus stray valids when quiet.
    always @(posedge clk) begin
        #1;
        mem_data_valid = 1'b0;
        mem_data_in    = 16'h0000;
        if (respQ.size() > 0 && respQ[0].due <= cyc && (!gapMode || (cyc % 2 == 1))) begin
            mem_data_valid = 1'b1;
            mem_data_in    = memWord(respQ[0].addr);
            void'(respQ.pop_front());
        end else if (respQ.size() == 0 && !mdlActive && strayEn && $urandom_range(0, 3) == 0) begin
            mem_data_valid = 1'b1;
            mem_data_in    = 16'($urandom);
        end
    end

    // Reference model and monitor: decides which request owns the memory,
    // predicts every output for this cycle and retires the fill on completion.
    always @(negedge clk) begin
        bit          expMemEn, expBusy, expWe, expDone;
        logic [15:0] expAddr;
        if (rst) begin
            mdlActive  = 1'b0;
            mdlWritten = 0;
            mdlTag     = -1;
            availIdle  = cyc + LAT + 1;
        end else begin
            if (!mdlActive && cyc >= availIdle) begin
                if (d_miss) begin
                    mdlActive = 1'b1; mdlOwner = 1'b1;
                    mdlBase   = d_miss_addr & 16'hFFF0;
                end else if (i_miss) begin
                    mdlActive = 1'b1; mdlOwner = 1'b0;
                    mdlBase   = i_miss_addr & 16'hFFF0;
                end
                if (mdlActive) begin
                    mdlStart = cyc + 1; mdlWritten = 0; mdlTag = -1;
                end
            end
            expBusy  = mdlActive && cyc >= mdlStart;
            expMemEn = expBusy && cyc < mdlStart + WORDS;
            expWe    = expBusy && mem_data_valid && mdlWritten < WORDS;
            expDone  = mdlActive && mdlTag >= 0 && cyc == mdlTag + 1;
            checkOutput("mem_en", 16'(mem_en), 16'(expMemEn));
            if (expMemEn) begin
                expAddr = mdlBase + 16'(2 * (cyc - mdlStart));
                checkOutput("mem_addr", mem_addr, expAddr);
            end
            checkOutput("fill_busy", 16'(fill_busy), 16'(expBusy));
            if (expBusy) checkOutput("fill_owner", 16'(fill_owner), 16'(mdlOwner));
            checkOutput("fill_we", 16'(fill_we), 16'(expWe));
            if (expWe) begin
                checkOutput("fill_word", 16'(fill_word), 16'(mdlWritten));
                checkOutput("fill_data", fill_data, memWord(mdlBase + 16'(2 * mdlWritten)));
                checkOutput("fill_tag_we", 16'(fill_tag_we), 16'(mdlWritten == WORDS - 1));
                if (mdlWritten == WORDS - 1) mdlTag = cyc;
                mdlWritten++;
            end else begin
                checkOutput("fill_tag_we_idle", 16'(fill_tag_we), 16'h0000);
            end
            checkOutput("fill_done", 16'(fill_done), 16'(expDone));
            checkOutput("i_stall", 16'(i_stall), 16'(i_miss && !(expDone && !mdlOwner)));
            checkOutput("d_stall", 16'(d_stall), 16'(d_miss && !(expDone && mdlOwner)));
            if (expDone) begin
                mdlActive = 1'b0;
                availIdle = cyc + 1;
            end
        end
    end

    task automatic stepCycles(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Waits for the owner's fill_done, then drops that miss like a cache that has its hit.
    task automatic waitDone(bit owner);
        bit found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clk);
            if (fill_done === 1'b1 && fill_owner === owner) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL fill_done_timeout owner %0d: got none expected pulse", owner);
        end
        @(posedge clk);
        #1;
        if (owner) d_miss = 1'b0;
        else       i_miss = 1'b0;
    endtask

    task automatic applyStimulus(bit doI, bit doD, logic [15:0] ia, logic [15:0] da, bit gap);
        gapMode = gap;
        if (doI) begin i_miss_addr = ia; i_miss = 1'b1; end
        if (doD) begin d_miss_addr = da; d_miss = 1'b1; end
        if (doD) waitDone(1'b1);
        if (doI) waitDone(1'b0);
        gapMode = 1'b0;
    endtask

    initial begin
        int seen;
        salt = 16'($urandom);
        $display("[TB] start, salt %h", salt);
        rst = 1'b1;
        stepCycles(2);
        rst = 1'b0;

        // Quiet period with stray valids while waiting and idle.
        strayEn = 1'b1;
        stepCycles(20);
        strayEn = 1'b0;

        // Single I-cache miss, then simultaneous misses, then a gappy memory.
        applyStimulus(1'b1, 1'b0, 16'h1236, 16'h0000, 1'b0);
        stepCycles(3);
        applyStimulus(1'b1, 1'b1, 16'h0040, 16'h8008, 1'b0);
        stepCycles(2);
        applyStimulus(1'b0, 1'b1, 16'h0000, 16'($urandom), 1'b1);

        // Reset after three words arrive; a D miss raised during the wait wins afterwards.
        stepCycles(2);
        i_miss_addr = 16'($urandom);
        i_miss = 1'b1;
        seen = 0;
        for (int k = 0; k < 100 && seen < 3; k++) begin
            @(negedge clk);
            if (fill_we === 1'b1) seen++;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        stepCycles(1);
        rst = 1'b0;
        stepCycles(2);
        d_miss_addr = 16'($urandom);
        d_miss = 1'b1;
        waitDone(1'b1);
        waitDone(1'b0);

        // Randomised traffic: mixed requesters, addresses, gaps and strays.
        for (int it = 0; it < 20; it++) begin
            int sel;
            strayEn = 1'b1;
            stepCycles($urandom_range(0, 5));
            strayEn = 1'b0;
            sel = $urandom_range(1, 3);
            applyStimulus(sel[0], sel[1], 16'($urandom), 16'($urandom), $urandom_range(0, 2) == 0);
        end

        stepCycles(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
